// File: rtl/frame_minmax_scanner.sv
// frame_minmax_scanner
//   Walks every pixel of a frame held in the frame buffer through a read port,
//   tracks the signed minimum and maximum, and hands the normalizer a minimum
//   and a conditioned range (max - min) together with a one-cycle done pulse.
//
// Ports
//   i_clk       clock
//   i_rst       synchronous active-high reset
//   i_start     scan request, only honoured while idle
//   o_busy      scan in progress
//   o_rd_valid  frame-buffer read request qualifier
//   o_rd_addr   frame-buffer read address
//   i_rd_data   signed pixel, arrives RD_LATENCY cycles after its request
//   o_min       signed minimum of the last completed scan
//   o_range     max - min of the last completed scan (saturated, never zero)
//   o_done      one-cycle pulse when o_min/o_range are updated
module frame_minmax_scanner #(
  parameter  int DATAW      = 16,
  parameter  int MAX_ADDR   = 768,
  parameter  int RD_LATENCY = 1,
  localparam int ADDRW      = $clog2(MAX_ADDR)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic                    o_rd_valid,
  output logic [ADDRW-1:0]        o_rd_addr,
  input  logic signed [DATAW-1:0] i_rd_data,
  output logic signed [DATAW-1:0] o_min,
  output logic signed [DATAW-1:0] o_range,
  output logic                    o_done
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

  localparam logic signed [DATAW-1:0] POS_MAX   = {1'b0, {(DATAW-1){1'b1}}};
  localparam logic signed [DATAW-1:0] NEG_MAX   = {1'b1, {(DATAW-1){1'b0}}};
  localparam logic signed [DATAW:0]   DIFF_SAT  = {2'b00, {(DATAW-1){1'b1}}};
  localparam logic signed [DATAW-1:0] ONE       = {{(DATAW-1){1'b0}}, 1'b1};
  localparam logic [ADDRW-1:0]        LAST_ADDR = ADDRW'(MAX_ADDR - 1);

  state_t                  state;
  logic [RD_LATENCY-1:0]   valid_pipe;
  logic signed [DATAW-1:0] run_min;
  logic signed [DATAW-1:0] run_max;
  logic signed [DATAW:0]   diff;
  logic signed [DATAW-1:0] range_next;
  logic                    sample_valid;

  // The oldest stage of the valid pipe lines up with the data returning now.
  assign sample_valid = valid_pipe[RD_LATENCY-1];

  // One extra bit keeps max - min exact for any pair of signed pixels.
  assign diff = {run_max[DATAW-1], run_max} - {run_min[DATAW-1], run_min};

  // Clamp the range to the positive output width, and never hand the
  // downstream divider a zero for a flat frame.
  always_comb begin
    range_next = diff[DATAW-1:0];
    if (diff > DIFF_SAT) begin
      range_next = POS_MAX;
    end else if (diff == '0) begin
      range_next = ONE;
    end
  end

  // Scan sequencer. Running min/max start at the opposite extremes so the first
  // returned sample always replaces both. DRAIN leaves only after the valid
  // pipe is completely empty, so the last sample is already folded in when the
  // results are registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      valid_pipe <= '0;
      run_min    <= '0;
      run_max    <= '0;
      o_busy     <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_addr  <= '0;
      o_min      <= '0;
      o_range    <= '0;
      o_done     <= 1'b0;
    end else begin
      valid_pipe <= RD_LATENCY'({valid_pipe, o_rd_valid});
      o_done     <= 1'b0;

      if (sample_valid) begin
        if (i_rd_data < run_min) run_min <= i_rd_data;
        if (i_rd_data > run_max) run_max <= i_rd_data;
      end

      case (state)
        IDLE: begin
          if (i_start) begin
            state      <= SCAN;
            o_busy     <= 1'b1;
            o_rd_valid <= 1'b1;
            o_rd_addr  <= '0;
            run_min    <= POS_MAX;
            run_max    <= NEG_MAX;
          end
        end
        SCAN: begin
          if (o_rd_addr == LAST_ADDR) begin
            o_rd_valid <= 1'b0;
            state      <= DRAIN;
          end else begin
            o_rd_addr <= o_rd_addr + ADDRW'(1);
          end
        end
        DRAIN: begin
          if (valid_pipe == '0) begin
            o_min   <= run_min;
            o_range <= range_next;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            state   <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_minmax_scanner.sv
// tb_frame_minmax_scanner
//   Directed bench for frame_minmax_scanner. Two instances share one frame
//   memory: one with a single-cycle read latency, one with three cycles.
//   A table of frame patterns with hand-computed min/range/latency is run
//   first, then hand-written sequences for ignored start, mid-scan reset and
//   back-to-back scans with start held high.
module tb_frame_minmax_scanner;

  localparam int DATAW = 16;
  localparam int NPIX  = 20;

  logic clk = 1'b0;
  logic rst;
  logic start1, start3;
  logic busy1, busy3;
  logic valid1, valid3;
  logic [4:0] addr1, addr3;
  logic signed [DATAW-1:0] data1, data3;
  logic signed [DATAW-1:0] min1, min3, range1, range3;
  logic done1, done3;

  logic signed [DATAW-1:0] mem [0:NPIX-1];
  logic signed [DATAW-1:0] p0, p1;

  int total_checks = 0;
  int passed_checks = 0;

  always #5 clk = ~clk;

  frame_minmax_scanner #(.DATAW(DATAW), .MAX_ADDR(NPIX), .RD_LATENCY(1)) u_lat1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .o_busy(busy1),
    .o_rd_valid(valid1), .o_rd_addr(addr1), .i_rd_data(data1),
    .o_min(min1), .o_range(range1), .o_done(done1)
  );

  frame_minmax_scanner #(.DATAW(DATAW), .MAX_ADDR(NPIX), .RD_LATENCY(3)) u_lat3 (
    .i_clk(clk), .i_rst(rst), .i_start(start3), .o_busy(busy3),
    .o_rd_valid(valid3), .o_rd_addr(addr3), .i_rd_data(data3),
    .o_min(min3), .o_range(range3), .o_done(done3)
  );

  // Frame-buffer models; outside a tracked return they drive extreme junk
  // that would corrupt the result if the scanner sampled it.
  always @(posedge clk) begin
    data1 <= valid1 ? mem[addr1] : 16'sh7FFF;
    p0    <= valid3 ? mem[addr3] : 16'sh8000;
    p1    <= p0;
    data3 <= p1;
  end

  typedef struct {
    int                      kind;
    bit                      use_l3;
    logic signed [DATAW-1:0] exp_min;
    logic signed [DATAW-1:0] exp_range;
    int                      exp_done;
  } vec_t;

  vec_t vecs [7];

  int done_edge, done_cnt, vcount, addr_err, last_valid;
  logic signed [DATAW-1:0] got_min, got_range, end_min, end_range;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total_checks++;
    if (actual == expected) passed_checks++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic fillMem(input int kind);
    for (int a = 0; a < NPIX; a++) begin
      case (kind)
        0: mem[a] = DATAW'(a - 5);
        1: mem[a] = 16'sd100;
        2: mem[a] = (a == 7) ? -16'sd32768 : ((a == 12) ? 16'sd32767 : 16'sd0);
        3: mem[a] = DATAW'(300 - a);
        4: mem[a] = -16'sd32768;
        5: mem[a] = (a == 0) ? -16'sd1 : 16'sd5;
        default: mem[a] = (a == 2) ? -16'sd2 : ((a == 15) ? 16'sd32766 : 16'sd0);
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start on the selected instance and watches 60 edges; edge 0 is
  // the edge that samples start.
  task automatic applyStimulus(input vec_t v);
    int expected_addr;
    logic vv, dd;
    logic [4:0] aa;
    fillMem(v.kind);
    done_edge = -1; done_cnt = 0; vcount = 0; addr_err = 0; last_valid = -1;
    expected_addr = 0;
    if (v.use_l3) start3 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0; start3 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      vv = v.use_l3 ? valid3 : valid1;
      aa = v.use_l3 ? addr3 : addr1;
      dd = v.use_l3 ? done3 : done1;
      if (vv) begin
        if (int'(aa) != expected_addr) addr_err++;
        expected_addr++;
        vcount++;
        last_valid = i;
      end
      if (dd) begin
        if (done_edge < 0) done_edge = i;
        done_cnt++;
        got_min   = v.use_l3 ? min3 : min1;
        got_range = v.use_l3 ? range3 : range1;
      end
      tick();
    end
    end_min   = v.use_l3 ? min3 : min1;
    end_range = v.use_l3 ? range3 : range1;
  endtask

  initial begin
    int prev_done, prev_valid, d1, d2, rise_after, double_done, dcount;

    vecs[0] = '{0, 1'b0, -16'sd5,     16'sd19,    22};
    vecs[1] = '{1, 1'b0, 16'sd100,    16'sd1,     22};
    vecs[2] = '{2, 1'b0, -16'sd32768, 16'sd32767, 22};
    vecs[3] = '{3, 1'b1, 16'sd281,    16'sd19,    24};
    vecs[4] = '{4, 1'b1, -16'sd32768, 16'sd1,     24};
    vecs[5] = '{5, 1'b0, -16'sd1,     16'sd6,     22};
    vecs[6] = '{6, 1'b1, -16'sd2,     16'sd32767, 24};

    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    fillMem(0);
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("reset busy",     busy1,  0);
    checkOutput("reset rd_valid", valid1, 0);
    checkOutput("reset rd_addr",  addr1,  0);
    checkOutput("reset min",      min1,   0);
    checkOutput("reset range",    range1, 0);
    checkOutput("reset done",     done1 | done3, 0);
    tick();

    for (int k = 0; k < 7; k++) begin
      applyStimulus(vecs[k]);
      checkOutput($sformatf("v%0d done edge", k),  done_edge,  vecs[k].exp_done);
      checkOutput($sformatf("v%0d done count", k), done_cnt,   1);
      checkOutput($sformatf("v%0d reads", k),      vcount,     NPIX);
      checkOutput($sformatf("v%0d addr order", k), addr_err,   0);
      checkOutput($sformatf("v%0d last read", k),  last_valid, NPIX - 1);
      checkOutput($sformatf("v%0d min", k),        got_min,    vecs[k].exp_min);
      checkOutput($sformatf("v%0d range", k),      got_range,  vecs[k].exp_range);
      checkOutput($sformatf("v%0d min hold", k),   end_min,    vecs[k].exp_min);
      checkOutput($sformatf("v%0d range hold", k), end_range,  vecs[k].exp_range);
    end

    // Second start pulse during the scan must be dropped, not queued.
    fillMem(0);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    d1 = -1; dcount = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 4) start1 = 1'b1;
      if (i == 5) start1 = 1'b0;
      if (i == 5) checkOutput("busy mid scan", busy1, 1);
      if (done1) begin
        dcount++;
        if (d1 < 0) d1 = i;
      end
      tick();
    end
    checkOutput("ignored start done count", dcount, 1);
    checkOutput("ignored start done edge",  d1, 22);

    // Reset at cycle 10 of a fresh scan: abort, clear outputs, no done.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    dcount = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 9) rst = 1'b1;
      if (i == 10) begin
        checkOutput("reset abort rd_valid", valid1, 0);
        checkOutput("reset abort min",      min1,   0);
        checkOutput("reset abort range",    range1, 0);
        checkOutput("reset abort busy",     busy1,  0);
        rst = 1'b0;
      end
      if (done1) dcount++;
      tick();
    end
    checkOutput("reset abort done count", dcount, 0);

    // Start held high: back-to-back scans with a single idle cycle between.
    fillMem(1);
    start1 = 1'b1;
    tick();
    d1 = -1; d2 = -1; rise_after = -1; double_done = 0;
    prev_done = 0; prev_valid = 1;
    for (int i = 0; i < 80; i++) begin
      if (done1 && prev_done) double_done++;
      if (done1 && !prev_done) begin
        if (d1 < 0) d1 = i;
        else if (d2 < 0) d2 = i;
      end
      if (valid1 && !prev_valid && d1 >= 0 && rise_after < 0) rise_after = i;
      prev_done  = done1;
      prev_valid = valid1;
      tick();
    end
    start1 = 1'b0;
    checkOutput("held first done edge",   d1, 22);
    checkOutput("held restart gap",       rise_after - d1, 2);
    checkOutput("held second done edge",  d2, 46);
    checkOutput("held done width",        double_done, 0);
    checkOutput("held min",               min1, 100);
    checkOutput("held range",             range1, 1);
    repeat (30) tick();

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
